// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch (IF) and load/store (LS)
// share one single-port 2048-word memory with a one-cycle response path.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic        if_err_o,
  output logic [31:0] if_rdata_o,
  // load/store port
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic        ls_err_o,
  output logic [31:0] ls_rdata_o,
  // memory port
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [10:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_LS   = 2'd2;

  logic [SW-1:0] starve_q, starve_d;
  logic [1:0]    owner_q, owner_d;
  logic          err_q, err_d;
  logic          rd_q, rd_d;

  logic          if_gnt_c, ls_gnt_c;
  logic          if_legal_c, ls_legal_c;
  logic          if_rvalid_c, ls_rvalid_c;

  // Region and alignment checks: IF lives in 0x0000-0x0FFF, LS in 0x1000-0x1FFF
  assign if_legal_c = (if_addr_i[1:0] == 2'b00) && (if_addr_i[31:12] == 20'd0);
  assign ls_legal_c = (ls_addr_i[1:0] == 2'b00) && (ls_addr_i[31:13] == 19'd0) &&
                      ls_addr_i[12];

  // Single-winner arbitration: LS has priority until IF has waited STARVE_LIMIT grants
  always_comb begin
    if_gnt_c = 1'b0;
    ls_gnt_c = 1'b0;
    if (!rst) begin
      if (if_req_i && ls_req_i) begin
        if (starve_q == STARVE_MAX) if_gnt_c = 1'b1;
        else                        ls_gnt_c = 1'b1;
      end else begin
        if_gnt_c = if_req_i;
        ls_gnt_c = ls_req_i;
      end
    end
  end

  // Memory strobes for the winning request; illegal requests never touch memory
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 11'd0;
    mem_wdata_o = 32'd0;
    if (if_gnt_c && if_legal_c) begin
      mem_en_o   = 1'b1;
      mem_be_o   = 4'hF;
      mem_addr_o = if_addr_i[12:2];
    end else if (ls_gnt_c && ls_legal_c) begin
      mem_en_o    = 1'b1;
      mem_we_o    = ls_we_i;
      mem_be_o    = ls_we_i ? ls_be_i : 4'hF;
      mem_addr_o  = ls_addr_i[12:2];
      mem_wdata_o = ls_we_i ? ls_wdata_i : 32'd0;
    end
  end

  // Next response owner and starvation count
  always_comb begin
    owner_d  = OWN_NONE;
    err_d    = 1'b0;
    rd_d     = 1'b0;
    starve_d = starve_q;
    if (if_gnt_c) begin
      owner_d = OWN_IF;
      err_d   = !if_legal_c;
      rd_d    = if_legal_c;
    end else if (ls_gnt_c) begin
      owner_d = OWN_LS;
      err_d   = !ls_legal_c;
      rd_d    = ls_legal_c && !ls_we_i;
    end
    if (!if_req_i || if_gnt_c) begin
      starve_d = '0;
    end else if (ls_gnt_c && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
    end
  end

  // Responses routed to the owner; rst masks a response still in flight
  assign if_rvalid_c = !rst && (owner_q == OWN_IF);
  assign ls_rvalid_c = !rst && (owner_q == OWN_LS);

  assign if_gnt_o    = if_gnt_c;
  assign ls_gnt_o    = ls_gnt_c;
  assign if_rvalid_o = if_rvalid_c;
  assign ls_rvalid_o = ls_rvalid_c;
  assign if_err_o    = if_rvalid_c && err_q;
  assign ls_err_o    = ls_rvalid_c && err_q;
  assign if_rdata_o  = (if_rvalid_c && rd_q) ? mem_rdata_i : 32'd0;
  assign ls_rdata_o  = (ls_rvalid_c && rd_q) ? mem_rdata_i : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a behavioural arbitration/memory model.
module tb_mem_arbiter;

  localparam int unsigned LIMIT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = 32'd0;
  logic        if_gnt_o, if_rvalid_o, if_err_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i = 1'b0;
  logic        ls_we_i = 1'b0;
  logic [3:0]  ls_be_i = 4'd0;
  logic [31:0] ls_addr_i = 32'd0;
  logic [31:0] ls_wdata_i = 32'd0;
  logic        ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [31:0] ls_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [10:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'd0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_err_o(if_err_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_err_o(ls_err_o), .ls_rdata_o(ls_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // Memory seen by the DUT: byte-enabled write, one-cycle read, junk otherwise
  logic [31:0] mem_arr [2048];
  always @(posedge clk) begin
    if (mem_en_o && mem_we_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) mem_arr[mem_addr_o][8*b +: 8] = mem_wdata_o[8*b +: 8];
    end
    if (mem_en_o && !mem_we_o) mem_rdata_i <= mem_arr[mem_addr_o];
    else                       mem_rdata_i <= $urandom;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [2048];
  int          m_starve = 0;
  logic        m_v = 1'b0;
  int          m_own = 0;
  logic        m_err = 1'b0;
  logic [31:0] m_data = 32'd0;
  logic        g_if, g_ls;

  // One clock cycle: drive inputs, check against model, advance the model
  task automatic step(input logic r, input logic iq, input logic [31:0] ia,
                      input logic lq, input logic lwe, input logic [3:0] lbe,
                      input logic [31:0] la, input logic [31:0] lwd);
    logic        eif, els, ileg, lleg;
    logic [48:0] em;
    logic [33:0] eifr, elsr;
    @(posedge clk); #1;
    rst = r; if_req_i = iq; if_addr_i = ia;
    ls_req_i = lq; ls_we_i = lwe; ls_be_i = lbe; ls_addr_i = la; ls_wdata_i = lwd;
    #3;
    eif = 1'b0; els = 1'b0;
    if (!r) begin
      if (iq && lq) begin
        if (m_starve == LIMIT) eif = 1'b1;
        else                   els = 1'b1;
      end else begin
        eif = iq; els = lq;
      end
    end
    ileg = (ia % 4 == 0) && (ia < 32'h1000);
    lleg = (la % 4 == 0) && (la >= 32'h1000) && (la < 32'h2000);
    em = '0;
    if (eif && ileg) em = {1'b1, 1'b0, 4'hF, ia[12:2], 32'h0};
    if (els && lleg) em = {1'b1, lwe, (lwe ? lbe : 4'hF), la[12:2], (lwe ? lwd : 32'h0)};
    eifr = '0; elsr = '0;
    if (!r && m_v) begin
      if (m_own == 1) eifr = {1'b1, m_err, m_data};
      else            elsr = {1'b1, m_err, m_data};
    end
    check_eq("gnt", 64'({if_gnt_o, ls_gnt_o}), 64'({eif, els}));
    check_eq("mem", 64'({mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}), 64'(em));
    check_eq("if_rsp", 64'({if_rvalid_o, if_err_o, if_rdata_o}), 64'(eifr));
    check_eq("ls_rsp", 64'({ls_rvalid_o, ls_err_o, ls_rdata_o}), 64'(elsr));
    m_v   = eif || els;
    m_own = eif ? 1 : 2;
    m_err = eif ? !ileg : !lleg;
    if (eif)                m_data = ileg ? ref_mem[ia[12:2]] : 32'h0;
    else                    m_data = (lleg && !lwe) ? ref_mem[la[12:2]] : 32'h0;
    if (els && lleg && lwe)
      for (int b = 0; b < 4; b++)
        if (lbe[b]) ref_mem[la[12:2]][8*b +: 8] = lwd[8*b +: 8];
    if (r || !iq || eif)                  m_starve = 0;
    else if (els && m_starve < int'(LIMIT)) m_starve++;
    g_if = eif; g_ls = els;
  endtask

  function automatic logic [31:0] gen_if_addr();
    case ($urandom_range(15))
      0:       return $urandom;
      1:       return 32'h1000 + 32'($urandom_range(1023) << 2);
      2:       return 32'($urandom_range(1023) << 2) | 32'($urandom_range(3, 1));
      default: return 32'($urandom_range(1023) << 2);
    endcase
  endfunction

  function automatic logic [31:0] gen_ls_addr();
    case ($urandom_range(15))
      0:       return $urandom;
      1:       return 32'($urandom_range(1023) << 2);
      2:       return 32'h1000 + 32'($urandom_range(15) << 2) + 32'($urandom_range(3, 1));
      default: return 32'h1000 + 32'($urandom_range(15) << 2);
    endcase
  endfunction

  initial begin
    logic [5:0]  pat;
    logic [31:0] v;
    logic        ip, lp, lwe;
    logic [31:0] ia, la, lwd;
    logic [3:0]  lbe;

    for (int i = 0; i < 2048; i++) begin
      v = $urandom;
      mem_arr[i] = v;
      ref_mem[i] = v;
    end
    mem_arr[0] = 32'h0000_0013;    ref_mem[0] = 32'h0000_0013;
    mem_arr[1024] = 32'h0;         ref_mem[1024] = 32'h0;

    // Reset holds everything quiet even with requests present
    step(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h1000, 32'h0);
    step(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h1000, 32'h0);
    check_eq("rst_outputs", 64'({if_gnt_o, if_rvalid_o, if_err_o, if_rdata_o, ls_gnt_o,
             ls_rvalid_o, ls_err_o, mem_en_o, mem_we_o, mem_be_o, mem_addr_o}), 64'h0);

    // Back-to-back fetches from word 0 and word 1
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_eq("fetch0_gnt", 64'({if_gnt_o, mem_addr_o}), 64'({1'b1, 11'd0}));
    step(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_eq("fetch1_gnt", 64'({if_gnt_o, mem_addr_o}), 64'({1'b1, 11'd1}));
    check_eq("fetch0_rdata", 64'(if_rdata_o), 64'h13);

    // Both requesting continuously: LS, LS, IF repeating
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 4'h0, 32'h1004, 32'h0);
      pat = {pat[4:0], if_gnt_o};
    end
    check_eq("starve_pattern", 64'(pat), 64'(6'b001001));

    // Partial store then load of the same word
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h1000, 32'hAABBCCDD);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h1000, 32'h0);
    check_eq("store_rsp", 64'({ls_rvalid_o, ls_err_o, ls_rdata_o}), {30'h0, 2'b10, 32'h0});
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_eq("load_after_store", 64'({ls_rvalid_o, ls_err_o, ls_rdata_o}),
             {30'h0, 2'b10, 32'h0000CCDD});

    // Illegal requests: LS in instruction region, IF in data region, misaligned LS
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0008, 32'h0);
    check_eq("ill_ls_en", 64'({ls_gnt_o, mem_en_o}), 64'(2'b10));
    step(1'b0, 1'b1, 32'h1000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_eq("ill_if_en", 64'({if_gnt_o, mem_en_o}), 64'(2'b10));
    check_eq("ill_ls_rsp", 64'({ls_rvalid_o, ls_err_o, ls_rdata_o}), {30'h0, 2'b11, 32'h0});
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h1002, 32'h0);
    check_eq("ill_mis_en", 64'({ls_gnt_o, mem_en_o}), 64'(2'b10));
    check_eq("ill_if_rsp", 64'({if_rvalid_o, if_err_o, if_rdata_o}), {30'h0, 2'b11, 32'h0});
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_eq("ill_mis_rsp", 64'({ls_rvalid_o, ls_err_o, ls_rdata_o}), {30'h0, 2'b11, 32'h0});

    // Reset right after a load grant kills its response
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h1008, 32'h0);
    step(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_eq("rst_kill_rsp", 64'({if_gnt_o, ls_gnt_o, ls_rvalid_o, ls_err_o, ls_rdata_o, mem_en_o}),
             64'h0);
    step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_eq("rst_release_gnt", 64'(if_gnt_o), 64'h1);

    // Random traffic honouring the hold-until-granted protocol
    ip = 1'b0; lp = 1'b0; ia = '0; la = '0; lwe = 1'b0; lbe = '0; lwd = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!ip && $urandom_range(3) != 0) begin
        ip = 1'b1; ia = gen_if_addr();
      end
      if (!lp && $urandom_range(3) != 0) begin
        lp = 1'b1; la = gen_ls_addr(); lwe = 1'($urandom_range(1));
        lbe = 4'($urandom); lwd = $urandom;
      end
      step(1'($urandom_range(63) == 0), ip, ia, lp, lwe, lbe, la, lwd);
      if (g_if) ip = 1'b0;
      if (g_ls) lp = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 2: maximum consecutive LS grants while IF waits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 if_req_i  input  1  instruction-fetch request; held with if_addr_i stable until granted.
REQ-005 if_addr_i  input  32  fetch byte address.
REQ-006 if_gnt_o  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid_o / if_err_o  output  1 / 1  fetch response valid / fetch error.
REQ-008 if_rdata_o  output  32  fetched instruction.
REQ-009 ls_req_i, ls_we_i  input  1, 1  load/store request; 1 = store.
REQ-010 ls_be_i  input  4  store byte enables.
REQ-011 ls_addr_i / ls_wdata_i  input  32 / 32  load/store byte address and store data; held until granted.
REQ-012 ls_gnt_o, ls_rvalid_o, ls_err_o  output  1 each  LS accept, response valid, error.
REQ-013 ls_rdata_o  output  32  load data.
REQ-014 mem_en_o, mem_we_o  output  1, 1  memory access strobe, write strobe.
REQ-015 mem_be_o / mem_addr_o  output  4 / 11  byte enables / word index for the 2048-word memory.
REQ-016 mem_wdata_o / mem_rdata_i  output 32 / input 32  write data / read data, valid one cycle after a read strobe.

Function
REQ-017 Memory map: words 0-1023 (bytes 0x0000-0x0FFF) instruction region; words 1024-2047 (0x1000-0x1FFF) data region; mem_addr_o = addr[12:2].
REQ-018 At most one grant per cycle; gnt is combinational in the cycle the winning req is high.
REQ-019 A granted, legal request drives mem_en_o=1 in the same cycle; mem_we_o=ls_we_i for LS; mem_we_o=0 and mem_be_o=4'hF for IF.
REQ-020 Arbitration: LS wins when both request, except IF wins when starve_cnt == STARVE_LIMIT.
REQ-021 starve_cnt: +1 when LS is granted while if_req_i=1; cleared when IF is granted or if_req_i=0; saturates at STARVE_LIMIT.
REQ-022 Response owner register, states NONE/IF/LS: set at grant, returns to NONE the next cycle unless a new grant occurs.
REQ-023 Response latency is exactly 1 cycle after grant for every request type: rvalid and err pulse for one cycle, routed to the owner.
REQ-024 Loads and fetches return mem_rdata_i on rdata; stores return rvalid=1, err=0, rdata=0.
REQ-025 Illegal request: addr[1:0]!=0, IF outside the instruction region, or LS outside the data region (including stores to the instruction region).
REQ-026 An illegal request is still granted but makes no memory access (mem_en_o=0); its response is rvalid=1, err=1, rdata=0.
REQ-027 When not granting, mem_en_o=0, mem_we_o=0, mem_be_o=0 and all other mem_* outputs are 0.
REQ-028 Back-to-back grants to the same or different requesters are allowed every cycle; throughput is one access per cycle.
REQ-029 A store followed by a load to the same word returns the stored data, relying on memory write-before-next-read.
REQ-030 rdata outputs are 0 whenever the matching rvalid is 0.

Reset
REQ-031 While rst=1: all outputs are 0, starve_cnt=0, owner=NONE, and no grants are issued.
REQ-032 Reset asserted the cycle after a grant suppresses that grant's rvalid and err.
REQ-033 After reset is released, the first request is granted in the first cycle rst=0.

Verification
REQ-034 IF only, if_addr_i=0x0000 then 0x0004 in consecutive cycles, mem word0=0x00000013 -> if_gnt_o both cycles, mem_addr_o=0 then 1, if_rdata_o=0x00000013 one cycle after the first grant.
REQ-035 IF and LS both continuously requesting, STARVE_LIMIT=2 -> grant pattern LS, LS, IF, LS, LS, IF.
REQ-036 LS store to 0x1000, be=4'b0011, wdata=0xAABBCCDD, then load from 0x1000, memory initially 0 -> store rvalid with err=0, then load ls_rdata_o=0x0000CCDD.
REQ-037 LS load from 0x0008, IF fetch from 0x1000, and LS load from 0x1002 -> each granted, mem_en_o=0, err=1 and rdata=0 one cycle later.
REQ-038 rst=1 in the cycle after an LS load grant -> ls_rvalid_o stays 0, all outputs 0; after release, a pending IF request is granted in the first cycle.
